// File: rtl/mul_seq_unit_pkg.sv
// Shared definitions for the Execute-stage multiplier: FSM encoding, flag bit
// positions and flag-write codes understood by the ALU and condition logic.
package mul_seq_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_NONE = 2'b00;

    // Multiplies never produce carry or overflow, so C and V stay clear.
    function automatic logic [3:0] make_nz_flags(input logic n, input logic z);
        logic [3:0] flags;
        flags         = 4'b0000;
        flags[FLAG_N] = n;
        flags[FLAG_Z] = z;
        return flags;
    endfunction

endpackage

// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier (MUL/MLA) for the Execute stage.
// Define MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module mul_seq_unit
    import mul_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic             CondExE,
    input  logic             FlushE,
    input  logic             SetFlagsE,
    input  logic             AccE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [WIDTH-1:0] SrcCE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] MulResult,
    output logic [3:0]       MulFlags,
    output logic [1:0]       MulFlagWrite
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    mul_state_t       state_r;
    mul_state_t       state_next_s;
    logic             accept_s;
    logic             last_iter_s;
    logic [WIDTH-1:0] product_next_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] product_r;
    logic [CNTW-1:0]  count_r;
    logic             setflags_r;
    logic [WIDTH-1:0] mul_result_r;
    logic [3:0]       mul_flags_r;

    assign accept_s = StartE & CondExE & ~FlushE &
                      ((state_r == ST_IDLE) | (state_r == ST_DONE));

    // Iteration datapath and termination test.
    always_comb begin
        product_next_s = product_r;
        if (mplier_r[0]) begin
            product_next_s = product_r + mcand_r;
        end else begin
            product_next_s = product_r;
        end
`ifdef MUL_EARLY_TERM_EN
        last_iter_s = (count_r == CNTW'(1)) | (mplier_r[WIDTH-1:1] == '0);
`else
        last_iter_s = (count_r == CNTW'(1));
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; flush overrides everything, including a new accept.
    always_comb begin
        state_next_s = state_r;
        if (FlushE) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = accept_s ? ST_RUN : ST_IDLE;
                ST_RUN:  state_next_s = last_iter_s ? ST_DONE : ST_RUN;
                ST_DONE: state_next_s = accept_s ? ST_RUN : ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: stall covers the issuing cycle, so BusyE is combinational.
    always_comb begin
        BusyE        = (state_r == ST_RUN) | accept_s;
        DoneE        = (state_r == ST_DONE);
        MulFlagWrite = FLAGW_NONE;
        if ((state_r == ST_DONE) && setflags_r) begin
            MulFlagWrite = FLAGW_NZ;
        end else begin
            MulFlagWrite = FLAGW_NONE;
        end
    end

    // Operand, product and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_r    <= '0;
            mplier_r   <= '0;
            product_r  <= '0;
            count_r    <= '0;
            setflags_r <= 1'b0;
        end else if (accept_s) begin
            mcand_r    <= SrcAE;
            mplier_r   <= SrcBE;
            product_r  <= AccE ? SrcCE : '0;
            count_r    <= CNTW'(WIDTH);
            setflags_r <= SetFlagsE;
        end else if (state_r == ST_RUN) begin
            mcand_r    <= mcand_r << 1;
            mplier_r   <= mplier_r >> 1;
            product_r  <= product_next_s;
            count_r    <= count_r - CNTW'(1);
        end
    end

    // Result and flags only change on a completion that is not being flushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_result_r <= '0;
            mul_flags_r  <= 4'b0000;
        end else if ((state_r == ST_RUN) && last_iter_s && !FlushE) begin
            mul_result_r <= product_next_s;
            mul_flags_r  <= make_nz_flags(product_next_s[WIDTH-1], product_next_s == '0);
        end
    end

    assign MulResult = mul_result_r;
    assign MulFlags  = mul_flags_r;

endmodule
